// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolver: evaluates RV32I/RV64I branch conditions on forwarded
// operands, trains a 2-bit saturating BHT, registers the resolution, counts branches.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush_in,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [2:0]       funct3,
    input  logic [1:0]       fub_cs_1,
    input  logic [1:0]       fub_cs_2,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  alu_out,
    input  logic [XLEN-1:0]  mem_out,
    input  logic             mem_out_valid,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             fetch_pred_taken,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_mispredict,
    output logic [XLEN-1:0]  res_target,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int BHT_N = 1 << BHT_IDX_W;

    logic [1:0]          bht_q [BHT_N];
    logic [1:0]          bht_d;
    logic                res_valid_q, res_taken_q, res_mispredict_q;
    logic [XLEN-1:0]     res_target_q, res_target_d;
    logic [CNT_W-1:0]    branch_count_q, branch_count_d;
    logic [CNT_W-1:0]    mispredict_count_q, mispredict_count_d;
    logic [XLEN-1:0]     op_a, op_b;
    logic [BHT_IDX_W-1:0] wr_idx, rd_idx;
    logic                taken, mispredict, f3_valid, accept, counted;
    logic                unused_fetch_bits;

    always_comb begin
        op_a = rs1;
        if (fub_cs_1 == 2'b10)      op_a = alu_out;
        else if (fub_cs_1 == 2'b01) op_a = mem_out;
        op_b = rs2;
        if (fub_cs_2 == 2'b10)      op_b = alu_out;
        else if (fub_cs_2 == 2'b01) op_b = mem_out;
    end

    // Handshake: a branch transfers on a cycle where in_valid && in_ready and flush_in is low;
    // in_ready drops only while a selected operand waits on mem_out, and decode then holds inputs.
    assign in_ready = !(((fub_cs_1 == 2'b01) || (fub_cs_2 == 2'b01)) && !mem_out_valid);
    assign accept   = in_valid && in_ready && !flush_in;

    always_comb begin
        taken    = 1'b0;
        f3_valid = 1'b1;
        case (funct3)
            3'b000:  taken = (op_a == op_b);
            3'b001:  taken = (op_a != op_b);
            3'b100:  taken = ($signed(op_a) < $signed(op_b));
            3'b101:  taken = ($signed(op_a) >= $signed(op_b));
            3'b110:  taken = (op_a < op_b);
            3'b111:  taken = (op_a >= op_b);
            default: f3_valid = 1'b0;
        endcase
    end

    // Invalid funct3 resolves as not-taken, so the mispredict flag reduces to in_pred_taken.
    assign mispredict   = taken ^ in_pred_taken;
    assign res_target_d = taken ? (in_pc + in_imm) : (in_pc + XLEN'(4));
    assign counted      = accept && f3_valid;

    assign wr_idx = in_pc[BHT_IDX_W+1:2];
    assign rd_idx = fetch_pc[BHT_IDX_W+1:2];
    assign unused_fetch_bits = ^{fetch_pc[XLEN-1:BHT_IDX_W+2], fetch_pc[1:0]};

    always_comb begin
        bht_d = bht_q[wr_idx];
        if (taken && bht_q[wr_idx] != 2'b11)       bht_d = bht_q[wr_idx] + 2'b01;
        else if (!taken && bht_q[wr_idx] != 2'b00) bht_d = bht_q[wr_idx] - 2'b01;
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (counted && branch_count_q != '1)
            branch_count_d = branch_count_q + CNT_W'(1);
        if (counted && mispredict && mispredict_count_q != '1)
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
        end else if (counted) begin
            bht_q[wr_idx] <= bht_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q        <= 1'b0;
            res_taken_q        <= 1'b0;
            res_mispredict_q   <= 1'b0;
            res_target_q       <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            res_valid_q        <= accept;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            if (accept) begin
                res_taken_q      <= taken;
                res_mispredict_q <= mispredict;
                res_target_q     <= res_target_d;
            end
        end
    end

    assign fetch_pred_taken = bht_q[rd_idx][1];
    assign res_valid        = res_valid_q;
    assign res_taken        = res_taken_q;
    assign res_mispredict   = res_mispredict_q;
    assign res_target       = res_target_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule
